// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the masked SRAM model and its clear sequencer.
package sram_pkg;

   typedef enum logic [0:0] {SRAM_IDLE, SRAM_CLEAR} sram_init_state_e;

   function automatic int unsigned sram_width(input int unsigned gran, input int unsigned seg);
      return gran * seg;
   endfunction

   function automatic bit read_lat_ok(input int unsigned lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Clear sequencer: walks every entry once after reset or on init_req, one write per cycle.
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          init_req_i,
   output logic          init_busy_o,
   output logic          clr_we_o,
   output logic [AW-1:0] clr_addr_o
);

   sram_init_state_e state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SRAM_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         SRAM_IDLE: begin
            if (init_req_i) begin
               state_d = SRAM_CLEAR;
               cnt_d   = '0;
            end
         end
         SRAM_CLEAR: begin
            // init_req is deliberately ignored here: a clear is never restarted or extended
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = SRAM_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = SRAM_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign init_busy_o = (state_q == SRAM_CLEAR);
   assign clr_we_o    = (state_q == SRAM_CLEAR);
   assign clr_addr_o  = cnt_q;

endmodule

// File: rtl/sram_rw_init_ext.sv
// Single-port masked SRAM model with hardware clear, selectable read latency and held rdata.
module sram_rw_init_ext
   import sram_pkg::*;
#(
   parameter int unsigned      DEPTH      = 256,
   parameter int unsigned      MASK_GRAN  = 21,
   parameter int unsigned      MASK_SEG   = 8,
   parameter int unsigned      READ_LAT   = 1,
   parameter logic [MASK_GRAN-1:0] INIT_VALUE = '0
) (
   input  logic                            RW0_clk,
   input  logic                            RW0_reset,
   input  logic [$clog2(DEPTH)-1:0]        RW0_addr,
   input  logic                            RW0_en,
   input  logic                            RW0_wmode,
   input  logic [MASK_SEG-1:0]             RW0_wmask,
   input  logic [MASK_GRAN*MASK_SEG-1:0]   RW0_wdata,
   output logic [MASK_GRAN*MASK_SEG-1:0]   RW0_rdata,
   output logic                            RW0_rvalid,
   input  logic                            init_req,
   output logic                            init_busy
);

   localparam int unsigned WIDTH = sram_width(MASK_GRAN, MASK_SEG);
   localparam int unsigned AW    = $clog2(DEPTH);

   if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
      $fatal(1, "sram_rw_init_ext: READ_LAT must be 1 or 2");
   end

   logic          clr_we;
   logic [AW-1:0] clr_addr;

   sram_init_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init_seq (
      .clk_i       (RW0_clk),
      .rst_i       (RW0_reset),
      .init_req_i  (init_req),
      .init_busy_o (init_busy),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr)
   );

   logic accept, in_range, usr_we, rd_acc;

   assign in_range = 32'(RW0_addr) < DEPTH;
   // init_req wins over a same-cycle request
   assign accept   = RW0_en & ~init_busy & ~init_req;
   assign usr_we   = accept & RW0_wmode & in_range;
   assign rd_acc   = accept & ~RW0_wmode;

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge RW0_clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= {MASK_SEG{INIT_VALUE}};
      end else if (usr_we) begin
         for (int i = 0; i < int'(MASK_SEG); i++) begin
            if (RW0_wmask[i]) begin
               mem_q[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   logic             rd1_valid_q;
   logic [WIDTH-1:0] rd1_data_q;

   always_ff @(posedge RW0_clk or posedge RW0_reset) begin
      if (RW0_reset) begin
         rd1_valid_q <= 1'b0;
         rd1_data_q  <= '0;
      end else begin
         rd1_valid_q <= rd_acc;
         if (rd_acc) begin
            rd1_data_q <= in_range ? mem_q[RW0_addr] : '0;
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic             rd2_valid_q;
      logic [WIDTH-1:0] rd2_data_q;

      always_ff @(posedge RW0_clk or posedge RW0_reset) begin
         if (RW0_reset) begin
            rd2_valid_q <= 1'b0;
            rd2_data_q  <= '0;
         end else begin
            rd2_valid_q <= rd1_valid_q;
            if (rd1_valid_q) begin
               rd2_data_q <= rd1_data_q;
            end
         end
      end

      assign RW0_rvalid = rd2_valid_q;
      assign RW0_rdata  = rd2_data_q;
   end else begin : g_lat1
      assign RW0_rvalid = rd1_valid_q;
      assign RW0_rdata  = rd1_data_q;
   end

`ifndef SYNTHESIS
   always @(posedge RW0_clk) begin
      if (accept && !in_range) begin
         $error("sram_rw_init_ext: out-of-range access to address %0d", RW0_addr);
      end
   end

`ifdef RANDOMIZE_MEM_INIT
   initial begin
      for (int e = 0; e < int'(DEPTH); e++) begin
         for (int b = 0; b < int'(WIDTH); b++) begin
            mem_q[e][b] = 1'($urandom);
         end
      end
   end
`endif
`endif

endmodule

// File: tb/tb_sram_rw_init_ext.sv
// Scoreboard bench: drives a READ_LAT=1 and a READ_LAT=2 instance with identical stimulus.
module tb_sram_rw_init_ext;

   localparam int D = 256;
   localparam int G = 21;
   localparam int S = 8;
   localparam int W = G * S;

   typedef struct {
      logic [W-1:0] data;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0, wmode = 1'b0, init = 1'b0;
   logic [7:0]   addr = '0;
   logic [S-1:0] wmask = '0;
   logic [W-1:0] wdata = '0;
   logic [W-1:0] rdata1, rdata2;
   logic         rvalid1, rvalid2, busy1, busy2;

   always #5 clk = ~clk;

   sram_rw_init_ext #(.DEPTH(D), .MASK_GRAN(G), .MASK_SEG(S), .READ_LAT(1)) dut1 (
      .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata1), .RW0_rvalid(rvalid1),
      .init_req(init), .init_busy(busy1)
   );

   sram_rw_init_ext #(.DEPTH(D), .MASK_GRAN(G), .MASK_SEG(S), .READ_LAT(2)) dut2 (
      .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata2), .RW0_rvalid(rvalid2),
      .init_req(init), .init_busy(busy2)
   );

   logic [W-1:0] mem_m [D];
   int           rem;
   int           cyc;
   exp_t         q1[$], q2[$];
   logic [W-1:0] held1, held2;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      check_eq("busy1", busy1, rem > 0);
      check_eq("busy2", busy2, rem > 0);
      if (q1.size() > 0 && q1[0].due == cyc) begin
         e = q1.pop_front();
         check_eq("rvalid1", rvalid1, 1'b1);
         check_eq("rdata1", rdata1, e.data);
         held1 = e.data;
      end else begin
         check_eq("rvalid1_idle", rvalid1, 1'b0);
         check_eq("rdata1_hold", rdata1, held1);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
         e = q2.pop_front();
         check_eq("rvalid2", rvalid2, 1'b1);
         check_eq("rdata2", rdata2, e.data);
         held2 = e.data;
      end else begin
         check_eq("rvalid2_idle", rvalid2, 1'b0);
         check_eq("rdata2_hold", rdata2, held2);
      end
   endtask

   // Called at a negedge; drives one cycle, advances the model at the posedge, checks at the next negedge.
   task automatic step(input logic e, input logic wm, input logic [7:0] a, input logic [S-1:0] m,
                       input logic [W-1:0] d, input logic ini);
      exp_t x;
      en = e; wmode = wm; addr = a; wmask = m; wdata = d; init = ini;
      @(posedge clk);
      cyc++;
      if (rem > 0) begin
         mem_m[D - rem] = '0;
         rem--;
      end else if (ini) begin
         rem = D;
      end else if (e) begin
         if (wm) begin
            for (int s = 0; s < S; s++) begin
               if (m[s]) mem_m[a][s*G +: G] = d[s*G +: G];
            end
         end else begin
            x.data = (int'(a) < D) ? mem_m[a] : '0;
            x.due  = cyc;
            q1.push_back(x);
            x.due  = cyc + 1;
            q2.push_back(x);
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, '0, '0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [S-1:0] m, input logic [W-1:0] d);
      step(1'b1, 1'b1, a, m, d, 1'b0);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b1, 1'b0, a, '0, '0, 1'b0);
   endtask

   task automatic run_clear();
      for (int k = 0; k < 2 * D && rem > 0; k++) idle(1);
      idle(1);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; init = 1'b0;
      #2;
      check_eq("rst_rdata1", rdata1, '0);
      check_eq("rst_rdata2", rdata2, '0);
      check_eq("rst_rvalid1", rvalid1, 1'b0);
      check_eq("rst_rvalid2", rvalid2, 1'b0);
      check_eq("rst_busy1", busy1, 1'b1);
      check_eq("rst_busy2", busy2, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rem = D;
      q1.delete();
      q2.delete();
      held1 = '0;
      held2 = '0;
   endtask

   initial begin
      logic [W-1:0] pat, d;
      cyc = 0;
      for (int i = 0; i < D; i++) mem_m[i] = 'x;
      pat = {21{8'h5A}};
      #1;

      // Power-on clear, then reads of cleared entries.
      do_reset();
      run_clear();
      rd(8'd0); rd(8'd128); rd(8'd255);
      idle(3);

      // Partial-mask write, then a no-op mask.
      wr(8'd3, 8'b1000_0001, pat);
      rd(8'd3);
      idle(3);
      wr(8'd3, 8'h00, ~pat);
      rd(8'd3);
      idle(3);

      // Held rdata is not disturbed by a later write.
      rd(8'd3);
      wr(8'd3, 8'hFF, {8{21'h1ABCDE}});
      idle(4);

      // Back-to-back pipelined reads and write-then-read of the same address.
      for (int i = 1; i <= 3; i++) begin
         for (int s = 0; s < S; s++) d[s*G +: G] = 21'(i * 1000 + s);
         wr(8'(i), 8'hFF, d);
      end
      rd(8'd1); rd(8'd2); rd(8'd3);
      idle(3);
      wr(8'd10, 8'hFF, ~pat);
      rd(8'd10);
      idle(3);

      // init wins over a same-cycle write; busy-time requests and init are dropped.
      wr(8'd5, 8'hFF, pat);
      step(1'b1, 1'b1, 8'd6, 8'hFF, pat, 1'b1);
      idle(10);
      wr(8'd5, 8'hFF, ~pat);
      rd(8'd7);
      step(1'b0, 1'b0, 8'd0, '0, '0, 1'b1);
      run_clear();
      rd(8'd5); rd(8'd6);
      idle(3);

      // Reset in the middle of a clear restarts it from entry 0.
      wr(8'd200, 8'hFF, pat);
      wr(8'd50, 8'hFF, pat);
      step(1'b0, 1'b0, 8'd0, '0, '0, 1'b1);
      idle(100);
      do_reset();
      run_clear();
      rd(8'd200); rd(8'd50);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
